// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD/LCM sequencer: default operand width,
// controller state encoding and the divider iteration count.
package gcd_pkg;

  // Default operand / GCD width.
  localparam int GCD_WIDTH = 11;

  // One quotient bit per cycle over the full-width product.
  localparam int DIV_CYCLES = 2 * GCD_WIDTH;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    DIV,
    DONE
  } state_t;

  // Divider iteration count for an arbitrary operand width.
  function automatic int div_cycles(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/lcm_seq_div.sv
// Sequential restoring divider: divides a 2*WIDTH-bit dividend by a
// WIDTH-bit divisor, producing one quotient bit per cycle, MSB first.
// 'done' is high during the final iteration and 'quotient' then already
// carries the complete result, so the caller can capture it on that edge.
module lcm_seq_div
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   quotient,
  output logic                 busy,
  output logic                 done
);

  localparam int STEPS = div_cycles(WIDTH);
  localparam int CW    = $clog2(STEPS + 1);

  // q_reg starts as the dividend; quotient bits shift in from the right
  // while dividend bits shift out of the top into the remainder.
  logic [2*WIDTH-1:0] q_reg, q_next;
  logic [WIDTH:0]     r_reg, r_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               busy_reg, busy_next;

  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     r_diff;
  logic               take;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    r_shift = {r_reg[WIDTH-1:0], q_reg[2*WIDTH-1]};
    r_diff  = r_shift - {1'b0, divisor};
    // r_reg[WIDTH] is the overflow bit of the shifted remainder; it is
    // always 0 when the remainder is kept below the divisor.
    take    = r_reg[WIDTH] | (r_shift >= {1'b0, divisor});
  end

  // Next-state for the iteration registers.
  always_comb begin
    q_next    = q_reg;
    r_next    = r_reg;
    cnt_next  = cnt_reg;
    busy_next = busy_reg;
    if (start) begin
      q_next    = dividend;
      r_next    = '0;
      cnt_next  = CW'(STEPS);
      busy_next = 1'b1;
    end else if (busy_reg) begin
      q_next   = {q_reg[2*WIDTH-2:0], take};
      r_next   = take ? r_diff : r_shift;
      cnt_next = cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_next = 1'b0;
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      r_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      r_reg    <= r_next;
      cnt_reg  <= cnt_next;
      busy_reg <= busy_next;
    end
  end

  assign quotient = {q_reg[2*WIDTH-2:0], take};
  assign busy     = busy_reg;
  assign done     = busy_reg && (cnt_reg == CW'(1));

endmodule

// File: rtl/gcd_lcm_sequencer.sv
// Initiator-side controller for a subtractive GCD core. Accepts operand
// pairs, loads the core, waits for a nonzero Y, then derives
// LCM = A*B/GCD with a sequential divider and returns {gcd, lcm, err}.
// Optional build macro: GCDSEQ_TIMEOUT_EN aborts WAIT after
// TIMEOUT_CYCLES cycles with err=1.
module gcd_lcm_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 gcd_load,
  output logic [WIDTH-1:0]     gcd_a,
  output logic [WIDTH-1:0]     gcd_b,
  input  logic [WIDTH-1:0]     gcd_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_gcd,
  output logic [2*WIDTH-1:0]   out_lcm,
  output logic                 out_err
);

  localparam int PW = 2 * WIDTH;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] gcd_a_reg, gcd_a_next;
  logic [WIDTH-1:0] gcd_b_reg, gcd_b_next;
  logic [WIDTH-1:0] gcd_reg, gcd_next;
  logic [PW-1:0]    lcm_reg, lcm_next;
  logic             err_reg, err_next;

  logic [PW-1:0]    product;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [PW-1:0]    div_quotient;

  logic             a_zero, b_zero, y_done;

`ifdef GCDSEQ_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0]   wait_cnt_reg, wait_cnt_next;
`endif

  assign product = PW'(gcd_a_reg) * PW'(gcd_b_reg);
  assign a_zero  = (gcd_a_reg == '0);
  assign b_zero  = (gcd_b_reg == '0);
  assign y_done  = (gcd_y != '0);

  lcm_seq_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (product),
    .divisor  (gcd_reg),
    .quotient (div_quotient),
    .busy     (div_busy),
    .done     (div_done)
  );

  // Next-state and result-register update for the controller FSM.
  always_comb begin
    state_next = state_reg;
    gcd_a_next = gcd_a_reg;
    gcd_b_next = gcd_b_reg;
    gcd_next   = gcd_reg;
    lcm_next   = lcm_reg;
    err_next   = err_reg;
    div_start  = 1'b0;
`ifdef GCDSEQ_TIMEOUT_EN
    wait_cnt_next = wait_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          gcd_a_next = in_a;
          gcd_b_next = in_b;
          if ((in_a == '0) && (in_b == '0)) begin
            // GCD(0,0) is undefined: report an error without using the core.
            gcd_next   = '0;
            lcm_next   = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
`ifdef GCDSEQ_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
        state_next = WAIT;
      end
      WAIT: begin
        // gcd_y was cleared by the core on the LOAD edge, so any nonzero
        // value seen here belongs to the current operand pair.
        if (y_done) begin
          gcd_next = gcd_y;
          err_next = 1'b0;
          if (a_zero || b_zero) begin
            lcm_next   = '0;
            state_next = DONE;
          end else if (!div_busy) begin
            div_start  = 1'b1;
            state_next = DIV;
          end
        end
`ifdef GCDSEQ_TIMEOUT_EN
        else if (wait_cnt_reg == TCW'(TIMEOUT_CYCLES)) begin
          gcd_next   = '0;
          lcm_next   = '0;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + TCW'(1);
        end
`endif
      end
      DIV: begin
        if (div_done) begin
          lcm_next   = div_quotient;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      gcd_a_reg <= '0;
      gcd_b_reg <= '0;
      gcd_reg   <= '0;
      lcm_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gcd_a_reg <= gcd_a_next;
      gcd_b_reg <= gcd_b_next;
      gcd_reg   <= gcd_next;
      lcm_reg   <= lcm_next;
      err_reg   <= err_next;
    end
  end

`ifdef GCDSEQ_TIMEOUT_EN
  // WAIT-cycle counter for the timeout abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`endif

  assign in_ready  = (state_reg == IDLE);
  assign gcd_load  = (state_reg == LOAD);
  assign out_valid = (state_reg == DONE);
  assign gcd_a     = gcd_a_reg;
  assign gcd_b     = gcd_b_reg;
  assign out_gcd   = gcd_reg;
  assign out_lcm   = lcm_reg;
  assign out_err   = err_reg;

endmodule
